// File: rtl/ultrasonic_pkg.sv
// Shared types and default timing for the ultrasonic scan scheduler.
package ultrasonic_pkg;

  localparam int unsigned CNT_W = 24;

  localparam int unsigned DEF_N_SENSORS    = 4;
  localparam int unsigned DEF_TRIG_CYCLES  = 120;     // 10 us at 12 MHz
  localparam int unsigned DEF_RISE_TIMEOUT = 60000;   // trigger end to echo rise
  localparam int unsigned DEF_ECHO_TIMEOUT = 456000;  // 38 ms of echo high
  localparam int unsigned DEF_SLOT_CYCLES  = 720000;  // 60 ms trigger to trigger

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_HOLDOFF
  } scan_state_e;

endpackage

// File: rtl/ultrasonic_scan_scheduler_echo_sync.sv
// Two-flop synchronizer for one asynchronous echo line plus rise detect.
module echo_sync (
  input  logic clk,
  input  logic reset,
  input  logic echo_async,
  output logic echo_s,
  output logic echo_rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronizer chain; prev_q remembers the last synchronized level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= echo_async;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign echo_s    = sync_q;
  // A line that is already high stays high with prev_q=1, so it never reads as an edge.
  assign echo_rise = sync_q & ~prev_q;

endmodule

// File: rtl/ultrasonic_scan_scheduler.sv
// Round-robin ultrasonic ranging scheduler: triggers one sensor per slot,
// times its echo pulse and reports the duration or a timeout.
module ultrasonic_scan_scheduler
  import ultrasonic_pkg::*;
#(
  parameter int unsigned N_SENSORS    = DEF_N_SENSORS,
  parameter int unsigned TRIG_CYCLES  = DEF_TRIG_CYCLES,
  parameter int unsigned RISE_TIMEOUT = DEF_RISE_TIMEOUT,
  parameter int unsigned ECHO_TIMEOUT = DEF_ECHO_TIMEOUT,
  parameter int unsigned SLOT_CYCLES  = DEF_SLOT_CYCLES,
  localparam int unsigned ID_W = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [N_SENSORS-1:0] sensor_mask,
  input  logic [N_SENSORS-1:0] echo,
  output logic [N_SENSORS-1:0] trig,
  output logic                 result_valid,
  output logic [ID_W-1:0]      result_id,
  output logic [CNT_W-1:0]     result_count,
  output logic                 result_timeout,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] RISE_LAST = CNT_W'(RISE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ECHO_MAX  = CNT_W'(ECHO_TIMEOUT);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);

  scan_state_e state_q, state_d;
  logic [ID_W-1:0]  sel_q, sel_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0] slot_q, slot_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rvalid_q, rvalid_d;
  logic [ID_W-1:0]  rid_q, rid_d;
  logic [CNT_W-1:0] rcount_q, rcount_d;
  logic             rtimeout_q, rtimeout_d;

  logic [N_SENSORS-1:0] echo_s;
  logic [N_SENSORS-1:0] echo_rise;
  logic [N_SENSORS-1:0] mask_rot;
  logic                 pick_found;
  logic [ID_W-1:0]      pick_idx;
  logic                 launch;
  logic [CNT_W-1:0]     cnt_inc;

  for (genvar g = 0; g < N_SENSORS; g++) begin : g_sync
    echo_sync u_echo_sync (
      .clk       (clk),
      .reset     (reset),
      .echo_async(echo[g]),
      .echo_s    (echo_s[g]),
      .echo_rise (echo_rise[g])
    );
  end

  // Mask rotated so bit 0 is the sensor just after the last one served.
  assign mask_rot = N_SENSORS'({sensor_mask, sensor_mask} >> (32'(last_q) + 32'd1));

  // Round-robin pick: first set bit of the rotated mask, mapped back to an index.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 0; k < N_SENSORS; k++) begin
      if (!pick_found && mask_rot[k]) begin
        pick_found = 1'b1;
        pick_idx   = ID_W'((32'(last_q) + 32'd1 + k) % N_SENSORS);
      end
    end
  end

  assign launch  = enable && pick_found;
  assign cnt_inc = cnt_q + 1'b1;

  // Next-state, slot timer, measure counter and result capture.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    slot_d     = slot_q;
    cnt_d      = cnt_q;
    rvalid_d   = 1'b0;
    rid_d      = rid_q;
    rcount_d   = rcount_q;
    rtimeout_d = rtimeout_q;

    if (state_q != S_IDLE) slot_d = slot_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_d = S_TRIG;
          sel_d   = pick_idx;
          last_d  = pick_idx;
          slot_d  = '0;
        end
      end
      S_TRIG: begin
        if (slot_q == TRIG_LAST) begin
          state_d = S_WAIT_RISE;
          cnt_d   = '0;
        end
      end
      S_WAIT_RISE: begin
        if (echo_rise[sel_q]) begin
          // The rise cycle is itself the first high cycle of the pulse.
          state_d = S_MEASURE;
          cnt_d   = CNT_W'(1);
        end else if (cnt_q == RISE_LAST) begin
          state_d    = S_HOLDOFF;
          rvalid_d   = 1'b1;
          rid_d      = sel_q;
          rcount_d   = '0;
          rtimeout_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_MEASURE: begin
        if (echo_s[sel_q]) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= ECHO_MAX) begin
            state_d    = S_HOLDOFF;
            rvalid_d   = 1'b1;
            rid_d      = sel_q;
            rcount_d   = ECHO_MAX;
            rtimeout_d = 1'b1;
          end
        end else begin
          state_d    = S_HOLDOFF;
          rvalid_d   = 1'b1;
          rid_d      = sel_q;
          rcount_d   = cnt_q;
          rtimeout_d = 1'b0;
        end
      end
      S_HOLDOFF: begin
        // The slot-end cycle doubles as the IDLE selection cycle so that
        // back-to-back triggers are exactly SLOT_CYCLES apart.
        if (slot_q >= SLOT_LAST) begin
          if (launch) begin
            state_d = S_TRIG;
            sel_d   = pick_idx;
            last_d  = pick_idx;
            slot_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      last_q     <= ID_W'(N_SENSORS - 1);
      slot_q     <= '0;
      cnt_q      <= '0;
      rvalid_q   <= 1'b0;
      rid_q      <= '0;
      rcount_q   <= '0;
      rtimeout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      slot_q     <= slot_d;
      cnt_q      <= cnt_d;
      rvalid_q   <= rvalid_d;
      rid_q      <= rid_d;
      rcount_q   <= rcount_d;
      rtimeout_q <= rtimeout_d;
    end
  end

  // Trigger decode straight from registered state so reset clears it at once.
  always_comb begin
    trig = '0;
    if (state_q == S_TRIG) trig[sel_q] = 1'b1;
  end

  assign busy           = (state_q != S_IDLE);
  assign result_valid   = rvalid_q;
  assign result_id      = rid_q;
  assign result_count   = rcount_q;
  assign result_timeout = rtimeout_q;

endmodule

// File: tb/tb_ultrasonic_scan_scheduler.sv
// Scoreboard bench for ultrasonic_scan_scheduler with scaled-down timing.
module tb_ultrasonic_scan_scheduler;

  localparam int N    = 4;
  localparam int TRIG = 12;
  localparam int RISE = 300;
  localparam int ET   = 1200;
  localparam int SLOT = 2000;

  localparam int M_FIXED  = 0;
  localparam int M_RANDOM = 1;
  localparam int M_NONE   = 2;
  localparam int M_STUCK  = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [N-1:0] sensor_mask;
  logic [N-1:0] echo;
  logic [N-1:0] trig;
  logic         result_valid;
  logic [1:0]   result_id;
  logic [23:0]  result_count;
  logic         result_timeout;
  logic         busy;

  typedef struct {
    int     id;
    int     count;
    bit     timeout;
    longint at;
  } exp_t;

  exp_t   exp_q[$];
  int     served[$];
  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;
  int     mode = M_FIXED;
  int     fixed_w = 1000;
  bit     exact_gap = 1'b0;
  bit     trig_forbidden = 1'b0;
  int     model_last = N - 1;
  int     results_seen = 0;
  int     trig_count = 0;

  ultrasonic_scan_scheduler #(
    .N_SENSORS   (N),
    .TRIG_CYCLES (TRIG),
    .RISE_TIMEOUT(RISE),
    .ECHO_TIMEOUT(ET),
    .SLOT_CYCLES (SLOT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .sensor_mask   (sensor_mask),
    .echo          (echo),
    .trig          (trig),
    .result_valid  (result_valid),
    .result_id     (result_id),
    .result_count  (result_count),
    .result_timeout(result_timeout),
    .busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t mk(input int id, input int count, input bit to, input longint at);
    exp_t e;
    e.id = id; e.count = count; e.timeout = to; e.at = at;
    return e;
  endfunction

  // Next enabled sensor after the last one served, wrapping around.
  function automatic int rr_next(input int last, input logic [N-1:0] m);
    logic [N-1:0] mm;
    mm = m;
    for (int k = 1; k <= N; k++) if (mm[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  // Sensor-side model: answers each trigger with an echo and predicts the result.
  task automatic respond(input int id);
    longint       c0;
    int           d;
    int           w;
    logic [N-1:0] noise;
    c0 = cyc;
    if (mode == M_NONE) begin
      exp_q.push_back(mk(id, 0, 1'b1, c0 + RISE));
    end else if (mode == M_STUCK) begin
      if (echo[id]) begin
        exp_q.push_back(mk(id, 0, 1'b1, c0 + RISE));
        repeat (RISE + 50) @(negedge clk);
        echo[id] = 1'b0;
      end else begin
        d = $urandom_range(0, RISE - 3);
        exp_q.push_back(mk(id, ET, 1'b1, c0 + d + ET + 2));
        repeat (d) @(negedge clk);
        echo[id] = 1'b1;
      end
    end else begin
      d = $urandom_range(0, RISE - 3);
      if ($urandom_range(0, 3) == 0) d = RISE - 3;
      if (mode == M_FIXED) w = fixed_w;
      else begin
        case ($urandom_range(0, 4))
          0:       w = 1;
          1:       w = ET - 1;
          2:       w = ET;
          default: w = $urandom_range(2, ET + 100);
        endcase
      end
      if (w >= ET) exp_q.push_back(mk(id, ET, 1'b1, c0 + d + ET + 2));
      else         exp_q.push_back(mk(id, w, 1'b0, c0 + d + w + 3));
      noise = N'($urandom());
      noise[id] = 1'b0;
      echo = noise;
      repeat (d) @(negedge clk);
      echo = '0;
      echo[id] = 1'b1;
      repeat (w) @(negedge clk);
      echo[id] = 1'b0;
    end
  endtask

  // Watches triggers: order, one-hot, width and spacing, then answers them.
  initial begin : sensor_side
    int           id;
    int           width;
    longint       prev_start;
    bit           have_prev;
    logic [N-1:0] t;
    echo = '0;
    have_prev = 1'b0;
    prev_start = 0;
    forever begin
      @(negedge clk);
      t = trig;
      if (reset) begin
        have_prev = 1'b0;
      end else if (t != '0) begin
        check("trig_onehot", $countones(t), 1);
        id = 0;
        for (int i = 0; i < N; i++) if (t[i]) id = i;
        check("trig_id", id, rr_next(model_last, sensor_mask));
        check("trig_when_none_allowed", trig_forbidden, 0);
        model_last = id;
        served.push_back(id);
        trig_count++;
        if (have_prev) begin
          if (exact_gap) check("trig_spacing", cyc - prev_start, SLOT);
          else           check("trig_spacing_min", longint'(cyc - prev_start >= SLOT), 1);
        end
        prev_start = cyc;
        have_prev = 1'b1;
        width = 0;
        while (trig[id] === 1'b1 && width <= TRIG + 4) begin
          width++;
          @(negedge clk);
        end
        if (reset) begin
          have_prev = 1'b0;
        end else begin
          check("trig_width", width, TRIG);
          respond(id);
        end
      end
    end
  end

  // Scoreboard monitor: pops an expectation on every result strobe.
  initial begin : monitor
    exp_t e;
    exp_t last_e;
    bit   have_last;
    have_last = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        have_last = 1'b0;
      end else if (result_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result_valid", result_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("result_id", result_id, e.id);
          check("result_count", result_count, e.count);
          check("result_timeout", result_timeout, e.timeout);
          check("result_cycle", cyc, e.at);
          last_e = e;
          have_last = 1'b1;
          results_seen++;
        end
      end else if (have_last && (cyc % 256 == 0)) begin
        check("hold_id", result_id, last_e.id);
        check("hold_count", result_count, last_e.count);
        check("hold_timeout", result_timeout, last_e.timeout);
      end
    end
  end

  task automatic wait_results(input int n, input string name);
    int target;
    int budget;
    target = results_seen + n;
    budget = (n + 2) * SLOT;
    while (results_seen < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check({name, "_results_arrived"}, results_seen, target);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_trig"}, trig, 0);
    check({name, "_result_valid"}, result_valid, 0);
    check({name, "_result_id"}, result_id, 0);
    check({name, "_result_count"}, result_count, 0);
    check({name, "_result_timeout"}, result_timeout, 0);
    check({name, "_busy"}, busy, 0);
  endtask

  initial begin : watchdog
    repeat (80000) @(posedge clk);
    failures++;
    $display("FAIL watchdog: got %0d cycles expected completion before 80000", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : main
    int base;
    int tc;
    int budget;
    reset = 1'b1;
    enable = 1'b0;
    sensor_mask = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // All four sensors, fixed 1000-cycle echoes, exact slot spacing.
    mode = M_FIXED;
    fixed_w = 1000;
    exact_gap = 1'b1;
    sensor_mask = 4'b1111;
    enable = 1'b1;
    wait_results(4, "all_four");
    for (int i = 0; i < 4; i++) check("order_all_four", served[i], i);

    // Alternating mask with randomized echo delay/width.
    base = served.size();
    sensor_mask = 4'b0101;
    mode = M_RANDOM;
    wait_results(4, "mask_0101");
    for (int i = 0; i < 4; i++) check("order_mask_0101", served[base + i], (i % 2) * 2);

    // Sensor 1 never answers: rise timeout.
    sensor_mask = 4'b0010;
    mode = M_NONE;
    wait_results(1, "rise_timeout");

    // Sensor 0 stuck high: echo timeout, then already-high line gives no edge.
    sensor_mask = 4'b0001;
    mode = M_STUCK;
    wait_results(2, "stuck_high");

    // Enable dropped while sensor 2 is measuring.
    sensor_mask = 4'b0100;
    mode = M_FIXED;
    fixed_w = 400;
    budget = 3 * SLOT;
    while (echo[2] !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("sensor2_echo_seen", echo[2], 1);
    repeat (20) @(negedge clk);
    enable = 1'b0;
    check("busy_during_measure", busy, 1);
    wait_results(1, "enable_drop");
    check("busy_in_holdoff", busy, 1);
    tc = trig_count;
    trig_forbidden = 1'b1;
    repeat (SLOT) @(negedge clk);
    check("idle_after_disable_busy", busy, 0);
    check("no_trig_after_disable", trig_count, tc);

    // Enabled with an empty mask stays idle.
    sensor_mask = '0;
    enable = 1'b1;
    repeat (50) @(negedge clk);
    check("empty_mask_busy", busy, 0);
    check("empty_mask_no_trig", trig_count, tc);

    // Reset asserted during TRIG.
    trig_forbidden = 1'b0;
    exact_gap = 1'b0;
    fixed_w = $urandom_range(50, 900);
    sensor_mask = 4'b1111;
    budget = 20;
    while (trig === '0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("trig_before_reset_seen", longint'(trig != '0), 1);
    repeat (5) @(negedge clk);
    #2;
    reset = 1'b1;
    model_last = N - 1;
    #1;
    check("trig_dropped_by_reset", trig, 0);
    check("busy_dropped_by_reset", busy, 0);
    repeat (3) @(negedge clk);
    check_reset_outputs("mid_slot_reset");
    check("no_pending_after_reset", exp_q.size(), 0);
    base = served.size();
    reset = 1'b0;
    wait_results(1, "after_reset");
    if (served.size() > base) check("first_after_reset_id", served[base], 0);
    else check("first_after_reset_trig_count", served.size(), base + 1);

    enable = 1'b0;
    repeat (10) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
